// File: rtl/enc_fifo_write_sequencer_if.sv
// Encoder byte stream plus DDR write-FIFO port, bundled for the write sequencer.
// The master side drives the stream and reports FIFO fullness; the slave side is the sequencer.
interface enc_fifo_write_sequencer_if;
  logic        frame_start;
  logic        frame_end;
  logic        data_valid;
  logic [7:0]  data;
  logic        fifo_afull;
  logic        fifo_wr;
  logic [63:0] fifo_data;

  modport master (
    output frame_start, frame_end, data_valid, data, fifo_afull,
    input  fifo_wr, fifo_data
  );

  modport slave (
    input  frame_start, frame_end, data_valid, data, fifo_afull,
    output fifo_wr, fifo_data
  );
endinterface

// File: rtl/enc_fifo_write_sequencer.sv
// Write-clock front end: frame-aligns the encoder byte stream, packs bytes into 64-bit
// FIFO words, drops or truncates frames under FIFO pressure and stretches EOF for sys_clk.
module enc_fifo_write_sequencer #(
  parameter int unsigned g_EOF_PULSE_LEN = 16,
  parameter int unsigned g_WCNT_WIDTH    = 24
) (
  input  logic                     wrclk_i,
  input  logic                     wrclk_reset_i,
  input  logic                     encoder_en_i,
  enc_fifo_write_sequencer_if.slave bus,
  output logic                     eof_o,
  output logic                     busy_o,
  output logic [g_WCNT_WIDTH-1:0]  frame_words_o,
  output logic [15:0]              drop_cnt_o
);

  typedef enum logic [2:0] {
    S_DISABLED,
    S_WAIT_SOF,
    S_CAPTURE,
    S_FLUSH,
    S_EOF_HOLD,
    S_DROP
  } state_t;

  localparam logic [7:0] HOLD_LAST = 8'(g_EOF_PULSE_LEN - 1);

  state_t                  state_q, state_nxt;
  logic                    en_meta_q, en_s_q;
  logic [2:0]              idx_q, idx_nxt;
  logic [7:0][7:0]         lanes_q, lanes_nxt, lanes_fill;
  logic                    trunc_q, trunc_nxt;
  logic [g_WCNT_WIDTH-1:0] wcnt_q, wcnt_nxt;
  logic [g_WCNT_WIDTH-1:0] words_q, words_nxt;
  logic [7:0]              hold_q, hold_nxt;
  logic [15:0]             drop_q, drop_nxt;
  logic                    drop_inc, accept, close;
  logic                    wr_q, wr_nxt;
  logic [63:0]             data_q, data_nxt;
  logic                    eof_q, busy_q;

  function automatic logic [g_WCNT_WIDTH-1:0] wcnt_inc(input logic [g_WCNT_WIDTH-1:0] v);
    return (&v) ? v : v + g_WCNT_WIDTH'(1);
  endfunction

  // encoder_en_i comes from sys_clk: two flops before anything looks at it.
  always_ff @(posedge wrclk_i or negedge wrclk_reset_i) begin
    if (!wrclk_reset_i) begin
      en_meta_q <= 1'b0;
      en_s_q    <= 1'b0;
    end else begin
      en_meta_q <= encoder_en_i;
      en_s_q    <= en_meta_q;
    end
  end

  // NOTE: state is clocked with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge wrclk_i or negedge wrclk_reset_i) begin
    if (!wrclk_reset_i) state_q <= S_DISABLED;
    else                state_q <= state_nxt;
  end

  // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    state_nxt  = state_q;
    idx_nxt    = idx_q;
    lanes_nxt  = lanes_q;
    lanes_fill = lanes_q;
    trunc_nxt  = trunc_q;
    wcnt_nxt   = wcnt_q;
    words_nxt  = words_q;
    hold_nxt   = hold_q;
    drop_inc   = 1'b0;
    accept     = 1'b0;
    close      = 1'b0;
    wr_nxt     = 1'b0;
    data_nxt   = data_q;

    unique case (state_q)
      S_DISABLED: begin
        if (en_s_q) state_nxt = S_WAIT_SOF;
      end

      S_WAIT_SOF: begin
        if (bus.frame_start) begin
          if (bus.fifo_afull) begin
            state_nxt = S_DROP;
            drop_inc  = 1'b1;
          end else begin
            state_nxt = S_CAPTURE;
            idx_nxt   = '0;
            lanes_nxt = '0;
            trunc_nxt = 1'b0;
            wcnt_nxt  = '0;
          end
        end
      end

      S_CAPTURE: begin
        accept = bus.data_valid && !trunc_q;
        close  = bus.frame_end || bus.frame_start;
        if (accept) begin
          lanes_fill[idx_q] = bus.data;
          idx_nxt           = idx_q + 3'd1;
          lanes_nxt         = lanes_fill;
          if (idx_q == 3'd7) begin
            // Clearing on commit keeps unfilled lanes zero for a later partial flush.
            lanes_nxt = '0;
            if (bus.fifo_afull) begin
              trunc_nxt = 1'b1;
              drop_inc  = 1'b1;
            end else begin
              wr_nxt   = 1'b1;
              data_nxt = lanes_fill;
              wcnt_nxt = wcnt_inc(wcnt_q);
            end
          end
        end
        // A new SOF here closes the open frame and the new one is lost.
        if (bus.frame_start) drop_inc = 1'b1;
        if (close) begin
          if (idx_nxt != 3'd0 && !trunc_nxt) begin
            state_nxt = S_FLUSH;
            wr_nxt    = 1'b1;
            data_nxt  = lanes_fill;
            wcnt_nxt  = wcnt_inc(wcnt_q);
          end else begin
            state_nxt = S_EOF_HOLD;
            hold_nxt  = '0;
            words_nxt = wcnt_nxt;
          end
          idx_nxt   = '0;
          lanes_nxt = '0;
        end
      end

      S_FLUSH: begin
        state_nxt = S_EOF_HOLD;
        hold_nxt  = '0;
        words_nxt = wcnt_q;
      end

      S_EOF_HOLD: begin
        if (bus.frame_start) drop_inc = 1'b1;
        if (hold_q == HOLD_LAST) state_nxt = S_WAIT_SOF;
        else                     hold_nxt  = hold_q + 8'd1;
      end

      S_DROP: begin
        if (bus.frame_end) state_nxt = S_WAIT_SOF;
      end

      default: state_nxt = S_DISABLED;
    endcase

    // Losing enable wins over everything: abandon the frame without a write or EOF.
    if (!en_s_q) begin
      state_nxt = S_DISABLED;
      wr_nxt    = 1'b0;
      drop_inc  = 1'b0;
    end

    drop_nxt = (drop_inc && drop_q != 16'hFFFF) ? drop_q + 16'd1 : drop_q;
    if (state_nxt == S_DISABLED) begin
      drop_nxt  = '0;
      words_nxt = '0;
    end
  end

  always_ff @(posedge wrclk_i or negedge wrclk_reset_i) begin
    if (!wrclk_reset_i) begin
      idx_q   <= '0;
      lanes_q <= '0;
      trunc_q <= 1'b0;
      wcnt_q  <= '0;
      words_q <= '0;
      hold_q  <= '0;
      drop_q  <= '0;
      wr_q    <= 1'b0;
      data_q  <= '0;
      eof_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      idx_q   <= idx_nxt;
      lanes_q <= lanes_nxt;
      trunc_q <= trunc_nxt;
      wcnt_q  <= wcnt_nxt;
      words_q <= words_nxt;
      hold_q  <= hold_nxt;
      drop_q  <= drop_nxt;
      wr_q    <= wr_nxt;
      data_q  <= data_nxt;
      // eof and busy are flopped from next-state so the CDC-facing pulse is glitch-free.
      eof_q   <= (state_nxt == S_EOF_HOLD);
      busy_q  <= (state_nxt == S_CAPTURE) || (state_nxt == S_FLUSH) ||
                 (state_nxt == S_EOF_HOLD);
    end
  end

  assign bus.fifo_wr   = wr_q;
  assign bus.fifo_data = data_q;
  assign eof_o         = eof_q;
  assign busy_o        = busy_q;
  assign frame_words_o = words_q;
  assign drop_cnt_o    = drop_q;

endmodule
